// File: rtl/music_resume_after_call_pkg.sv
// music_resume_after_call shared types and defaults.
// State encoding, default parameters and counter sizing helper.
package music_resume_after_call_pkg;

  localparam int GUARD_CYCLES_DEF     = 4;
  localparam int VOL_W_DEF            = 4;
  localparam int RAMP_STEP_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_SUSPENDED = 3'd2,
    ST_GUARD     = 3'd3,
    ST_RAMP      = 3'd4
  } state_e;

  // One counter width covers both the guard and the ramp step timer.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/music_resume_after_call_if.sv
// Phone-event / audio-output bundle for music_resume_after_call.
// master: event sources + audio sink; slave: the controller.
interface music_resume_after_call_if #(
  parameter int VOL_W = music_resume_after_call_pkg::VOL_W_DEF
);

  logic             is_ringing;
  logic             in_call;
  logic             play_req;
  logic             stop_req;
  logic             music;
  logic [VOL_W-1:0] volume;
  logic             resumed;

  modport master (
    output is_ringing,
    output in_call,
    output play_req,
    output stop_req,
    input  music,
    input  volume,
    input  resumed
  );

  modport slave (
    input  is_ringing,
    input  in_call,
    input  play_req,
    input  stop_req,
    output music,
    output volume,
    output resumed
  );

endinterface

// File: rtl/music_resume_after_call_volume_ramp.sv
// Saturating volume register with a per-step cycle counter.
// Ports: clr, load/load_val, en (step) in; volume, at_max out.
module music_resume_after_call_volume_ramp
  import music_resume_after_call_pkg::*;
#(
  parameter int VOL_W       = VOL_W_DEF,
  parameter int STEP_CYCLES = RAMP_STEP_CYCLES_DEF,
  parameter int CNT_W       = cnt_width(GUARD_CYCLES_DEF,
                                        RAMP_STEP_CYCLES_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [VOL_W-1:0] load_val,
  input  logic             en,
  output logic [VOL_W-1:0] volume,
  output logic             at_max
);

  localparam logic [VOL_W-1:0] MAX_VOL  = '1;
  localparam logic [VOL_W-1:0] NEAR_MAX = MAX_VOL - VOL_W'(1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(STEP_CYCLES - 1);

  logic [VOL_W-1:0] vol_q, vol_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             step_zero;

  assign step_zero = (step_q == '0);

  // Flags that the next enabled cycle lands the volume on MAX_VOL,
  // so the controller can leave the ramp on that same edge.
  assign at_max = step_zero && (vol_q == NEAR_MAX);

  assign volume = vol_q;

  always_comb begin
    vol_d  = vol_q;
    step_d = step_q;
    unique case (1'b1)
      clr: begin
        vol_d  = '0;
        step_d = '0;
      end
      load: begin
        vol_d  = load_val;
        step_d = RELOAD;
      end
      en: begin
        if (step_zero) begin
          step_d = RELOAD;
          if (vol_q != MAX_VOL) begin
            vol_d = vol_q + VOL_W'(1);
          end
        end else begin
          step_d = step_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vol_q  <= '0;
      step_q <= '0;
    end else begin
      vol_q  <= vol_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/music_resume_after_call.sv
// Mutes music on ring/call and fades it back in after a guard time.
// Ports: clock, reset (async low), bus (slave: events in, audio out).
module music_resume_after_call
  import music_resume_after_call_pkg::*;
#(
  parameter int GUARD_CYCLES     = GUARD_CYCLES_DEF,
  parameter int VOL_W            = VOL_W_DEF,
  parameter int RAMP_STEP_CYCLES = RAMP_STEP_CYCLES_DEF
) (
  input logic                    clock,
  input logic                    reset,
  music_resume_after_call_if.slave bus
);

  localparam int CNT_W = cnt_width(GUARD_CYCLES, RAMP_STEP_CYCLES);

  localparam logic [VOL_W-1:0] MAX_VOL = '1;
  localparam logic [VOL_W-1:0] VOL_ONE = VOL_W'(1);
  localparam logic [CNT_W-1:0] GUARD_RELOAD =
    CNT_W'(GUARD_CYCLES - 1);

  state_e           state_q, state_d;
  logic             music_q, music_d;
  logic             resumed_q, resumed_d;
  logic [CNT_W-1:0] guard_q, guard_d;

  logic             busy;
  logic             vr_clr;
  logic             vr_load;
  logic             vr_en;
  logic [VOL_W-1:0] vr_load_val;
  logic             vr_at_max;

  assign busy = bus.is_ringing | bus.in_call;

  assign bus.music   = music_q;
  assign bus.resumed = resumed_q;

  music_resume_after_call_volume_ramp #(
    .VOL_W      (VOL_W),
    .STEP_CYCLES(RAMP_STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ramp (
    .clock   (clock),
    .reset   (reset),
    .clr     (vr_clr),
    .load    (vr_load),
    .load_val(vr_load_val),
    .en      (vr_en),
    .volume  (bus.volume),
    .at_max  (vr_at_max)
  );

  always_comb begin
    state_d     = state_q;
    music_d     = music_q;
    resumed_d   = 1'b0;
    guard_d     = guard_q;
    vr_clr      = 1'b0;
    vr_load     = 1'b0;
    vr_en       = 1'b0;
    vr_load_val = '0;
    unique case (state_q)
      ST_STOPPED: begin
        if (bus.play_req) begin
          if (busy) begin
            state_d = ST_SUSPENDED;
          end else begin
            state_d     = ST_PLAYING;
            music_d     = 1'b1;
            vr_load     = 1'b1;
            vr_load_val = MAX_VOL;
          end
        end
      end
      ST_PLAYING: begin
        if (bus.stop_req || busy) begin
          state_d = bus.stop_req ? ST_STOPPED
                                 : ST_SUSPENDED;
          music_d = 1'b0;
          vr_clr  = 1'b1;
        end
      end
      ST_SUSPENDED: begin
        if (bus.stop_req) begin
          state_d = ST_STOPPED;
        end else if (!busy) begin
          state_d = ST_GUARD;
          guard_d = GUARD_RELOAD;
        end
      end
      ST_GUARD: begin
        if (bus.stop_req || busy) begin
          state_d = bus.stop_req ? ST_STOPPED
                                 : ST_SUSPENDED;
          guard_d = '0;
        end else if (guard_q == '0) begin
          state_d     = ST_RAMP;
          music_d     = 1'b1;
          vr_load     = 1'b1;
          vr_load_val = VOL_ONE;
        end else begin
          guard_d = guard_q - CNT_W'(1);
        end
      end
      ST_RAMP: begin
        if (bus.stop_req || busy) begin
          state_d = bus.stop_req ? ST_STOPPED
                                 : ST_SUSPENDED;
          music_d = 1'b0;
          vr_clr  = 1'b1;
        end else begin
          vr_en = 1'b1;
          if (vr_at_max) begin
            state_d   = ST_PLAYING;
            resumed_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_STOPPED;
        music_d = 1'b0;
        guard_d = '0;
        vr_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOPPED;
      music_q   <= 1'b0;
      resumed_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      music_q   <= music_d;
      resumed_q <= resumed_d;
      guard_q   <= guard_d;
    end
  end

endmodule

// File: tb/tb_music_resume_after_call.sv
// Randomized bench for music_resume_after_call.
// Reference model tracks user intent and idle time since the call.
module tb_music_resume_after_call;

  localparam int G    = 4;
  localparam int VW   = 4;
  localparam int R    = 2;
  localparam int MAXV = (1 << VW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  music_resume_after_call_if #(.VOL_W(VW)) bus ();

  music_resume_after_call #(
    .GUARD_CYCLES    (G),
    .VOL_W           (VW),
    .RAMP_STEP_CYCLES(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: the user wants music, it is fully on, or it was cut by
  // the phone and `idle` counts consecutive quiet edges since then.
  bit want;
  bit full;
  bit susp;
  int idle;
  int e_music;
  int e_vol;
  int e_res;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ramp_vol(input int i);
    int v;
    v = 1 + (i - G - 1) / R;
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_outputs();
    if (full) begin
      e_music = 1;
      e_vol   = MAXV;
    end else if (susp && idle > G) begin
      e_music = 1;
      e_vol   = ramp_vol(idle);
    end else begin
      e_music = 0;
      e_vol   = 0;
    end
  endtask

  task automatic model_reset();
    want  = 0;
    full  = 0;
    susp  = 0;
    idle  = 0;
    e_res = 0;
    model_outputs();
  endtask

  task automatic model_edge(input bit ring, input bit call,
                            input bit play, input bit stop);
    bit busy;
    busy  = ring | call;
    e_res = 0;
    if (!want) begin
      if (play) begin
        want = 1;
        full = !busy;
        susp = busy;
        idle = 0;
      end
    end else if (stop) begin
      want = 0;
      full = 0;
      susp = 0;
      idle = 0;
    end else if (busy) begin
      full = 0;
      susp = 1;
      idle = 0;
    end else if (susp) begin
      idle++;
      if (idle > G && ramp_vol(idle) >= MAXV) begin
        susp  = 0;
        full  = 1;
        e_res = 1;
      end
    end
    model_outputs();
  endtask

  task automatic step(input bit ring, input bit call,
                      input bit play, input bit stop);
    @(negedge clock);
    bus.is_ringing = ring;
    bus.in_call    = call;
    bus.play_req   = play;
    bus.stop_req   = stop;
    @(posedge clock);
    model_edge(ring, call, play, stop);
    #1;
    chk("music",   int'(bus.music),   e_music);
    chk("volume",  int'(bus.volume),  e_vol);
    chk("resumed", int'(bus.resumed), e_res);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  bit r_ring;
  bit r_call;

  initial begin
    bus.is_ringing = 0;
    bus.in_call    = 0;
    bus.play_req   = 0;
    bus.stop_req   = 0;
    model_reset();

    #30;
    chk("rst_music",   int'(bus.music),   0);
    chk("rst_volume",  int'(bus.volume),  0);
    chk("rst_resumed", int'(bus.resumed), 0);
    @(negedge clock);
    reset = 1'b1;

    quiet(2);
    step(0, 0, 1, 0);
    chk("play_full", int'(bus.volume), MAXV);

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    quiet(40);

    step(1, 0, 0, 0);
    quiet(2);
    step(0, 1, 0, 0);
    quiet(40);

    step(1, 0, 0, 0);
    for (int i = 0; i < 40 && bus.volume != 6; i++) step(0, 0, 0, 0);
    chk("reach_vol6", int'(bus.volume), 6);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    quiet(40);

    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    quiet(40);
    step(1, 0, 0, 1);
    quiet(3);

    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40 && bus.volume != 9; i++) step(0, 0, 0, 0);
    chk("reach_vol9", int'(bus.volume), 9);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_music",   int'(bus.music),   0);
    chk("async_volume",  int'(bus.volume),  0);
    chk("async_resumed", int'(bus.resumed), 0);
    @(negedge clock);
    reset = 1'b1;
    quiet(3);

    r_ring = 0;
    r_call = 0;
    for (int i = 0; i < 4000; i++) begin
      if (r_ring) r_ring = ($urandom_range(0, 7) != 0);
      else        r_ring = ($urandom_range(0, 59) == 0);
      if (r_call) r_call = ($urandom_range(0, 11) != 0);
      else        r_call = ($urandom_range(0, 89) == 0);
      step(r_ring, r_call,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/music_resume_after_call.md
Name: music_resume_after_call

Overview:
Companion to the phone-ring music cutoff. It is the resume side: it mutes music while the phone rings or a call is in progress, then restores playback after the call ends. Restoring waits a guard interval, then ramps the volume back up. It owns the user play/stop intent, so music resumes only if the user still wants it. It sits between the phone event sources (is_ringing, in_call) and the audio output stage.

Parameters:
GUARD_CYCLES, 4, full idle cycles (no ring, no call) required before resuming; legal range 1..255.
VOL_W, 4, volume output width; MAX_VOL = 2**VOL_W-1.
RAMP_STEP_CYCLES, 2, clock cycles per +1 volume step during fade-in; legal range 1..255.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
is_ringing  input  1  phone ringing, level.
in_call  input  1  call in progress, level.
play_req  input  1  user play request, one-cycle pulse.
stop_req  input  1  user stop request, one-cycle pulse.
music  output  1  music enabled, registered.
volume  output  VOL_W  current volume, registered.
resumed  output  1  one-cycle pulse when fade-in completes.

Behaviour:
- busy = is_ringing | in_call. All inputs are sampled on the rising clock edge. All outputs are registered and change on the edge that samples the cause.
- Reset (reset=0, asynchronous): state STOPPED, music=0, volume=0, resumed=0, counters=0. Reset asserted mid-operation aborts immediately. After release, stays STOPPED until play_req.
- State STOPPED: music=0, volume=0.
  - play_req & !busy -> PLAYING, volume=MAX_VOL.
  - play_req & busy -> SUSPENDED (deferred play).
- State PLAYING: music=1, volume=MAX_VOL.
  - stop_req -> STOPPED.
  - else busy -> SUSPENDED.
- State SUSPENDED: music=0, volume=0.
  - stop_req -> STOPPED.
  - else !busy -> GUARD, guard counter loaded with GUARD_CYCLES-1.
- State GUARD: music=0, volume=0.
  - stop_req -> STOPPED.
  - else busy -> SUSPENDED (counter discarded).
  - else counter==0 -> RAMP, music=1, volume=1, step counter=RAMP_STEP_CYCLES-1.
  - else counter decrements.
- State RAMP: music=1.
  - stop_req -> STOPPED.
  - else busy -> SUSPENDED (music=0, volume=0 on the same edge).
  - else when step counter==0: volume+1 and step counter reloads. If the new volume==MAX_VOL: -> PLAYING, resumed=1 for exactly one cycle.
- Priority every state: reset > stop_req > busy > play_req > timers. play_req in PLAYING, SUSPENDED, GUARD or RAMP is ignored. stop_req in STOPPED is ignored.
- Volume never wraps: saturates at MAX_VOL and never goes below 0. Counters are sized $clog2(max(GUARD_CYCLES,RAMP_STEP_CYCLES)+1).
- Timing with defaults: busy low first sampled at edge n puts the block in GUARD at edge n. It enters RAMP at edge n+4 (music=1, volume=1). Volume reaches 15 at edge n+4+28, with resumed high for the following cycle.
- music=0 implies volume=0 in every state.

Decomposition:
- Shared header music_ctrl_defs.vh holds:
  - state encodings ST_STOPPED=0, ST_PLAYING=1, ST_SUSPENDED=2, ST_GUARD=3, ST_RAMP=4 (3-bit);
  - the default parameter values.
- One natural sub-module, volume_ramp: the step counter plus saturating volume register with load/clear/enable inputs and an at_max flag.
- The top level holds the FSM and the guard counter.

Test Plan:
- Reset then play: reset=0 for 30ns, release, play_req pulse with busy=0 -> next edge music=1, volume=15; no resumed pulse.
- Ring while playing: from PLAYING, is_ringing=1 -> same sampling edge music=0, volume=0. Hold 5 cycles, is_ringing=0 -> music stays 0 for 4 cycles, then music=1, volume=1, rising by 1 every 2 cycles. resumed pulses once when volume=15.
- Ring retrigger during guard: in GUARD after 2 idle cycles, in_call=1 for 1 cycle -> back to SUSPENDED. The guard restarts with a full 4 cycles after in_call drops.
- Stop during ramp: stop_req at volume=6 -> next edge music=0, volume=0, STOPPED. Call ending later does not restart music.
- Deferred play and simultaneous events: play_req while in_call=1 -> music stays 0; call ends -> guard then ramp. stop_req and is_ringing asserted on the same edge while PLAYING -> STOPPED, not SUSPENDED.
- Async reset mid-ramp: reset=0 between edges at volume=9 -> music=0, volume=0 immediately, with no clock edge needed.
